// File: rtl/histogram_peak_reader.sv
// histogram_peak_reader
// ---------------------
// Reads out the x/y projection histograms after the filter finishes, keeps
// the peak bin (lowest index on ties) and optional bin-count totals per
// axis, clears the histogram, then offers the result downstream.
//
// Optional feature macro: HIST_TOTAL_EN builds the xTotal/yTotal
// accumulators; without it both outputs are tied to 0.
//
// Ports
//   clk, reset          clock (rising edge), asynchronous active-low reset
//   filterDone          start pulse, honoured only in IDLE
//   readHistogram       one-cycle readout request (REQUEST state)
//   clearHistogram      one-cycle clear request (CLEAR state)
//   x/yHistogramOut     bin counts, qualified by x/yValid
//   x/yValid            one bin per high cycle, bin 0 first
//   histogramClear      clear-complete acknowledge (level or pulse)
//   x/yPeakIndex/Count  peak bin and its count
//   x/yTotal            sum of accepted bin counts (0 without HIST_TOTAL_EN)
//   resultValid         result offered; outputs frozen while high
//   resultAck           consumer accepts the result
//   clearError          sticky: clear acknowledge timed out
//   busy                high in every state except IDLE
//   dbg_state           current FSM state, for observation
//
// Handshake: resultValid is high exactly in DONE and the result registers do
// not change there; resultAck is only looked at in DONE, and an ack sampled
// on an edge returns the block to IDLE for the following cycle. Acking in
// the same cycle resultValid rises is allowed.
module histogram_peak_reader #(
  parameter int NUM_BINS      = 256,
  parameter int CLEAR_TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        filterDone,
  output logic        readHistogram,
  output logic        clearHistogram,
  input  logic [7:0]  xHistogramOut,
  input  logic [7:0]  yHistogramOut,
  input  logic        xValid,
  input  logic        yValid,
  input  logic        histogramClear,
  output logic [7:0]  xPeakIndex,
  output logic [7:0]  yPeakIndex,
  output logic [7:0]  xPeakCount,
  output logic [7:0]  yPeakCount,
  output logic [15:0] xTotal,
  output logic [15:0] yTotal,
  output logic        resultValid,
  input  logic        resultAck,
  output logic        clearError,
  output logic        busy,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_REQUEST    = 3'd1,
    S_COLLECT    = 3'd2,
    S_CLEAR      = 3'd3,
    S_WAIT_CLEAR = 3'd4,
    S_DONE       = 3'd5
  } state_e;

  localparam logic [8:0]  BINS    = 9'(NUM_BINS);
  localparam logic [15:0] TIMEOUT = 16'(CLEAR_TIMEOUT);

  state_e      state_q, state_d;
  logic [8:0]  x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
  logic [7:0]  x_idx_q, x_idx_d, y_idx_q, y_idx_d;
  logic [7:0]  x_peak_q, x_peak_d, y_peak_q, y_peak_d;
  logic [15:0] tmo_q, tmo_d;
  logic        err_q, err_d;
  logic        x_beat, y_beat;
`ifdef HIST_TOTAL_EN
  logic [15:0] x_tot_q, x_tot_d, y_tot_q, y_tot_d;
`endif

  // A beat counts only while collecting and before the axis has all its
  // bins; the beat counter doubles as the bin index.
  assign x_beat = (state_q == S_COLLECT) && xValid && (x_cnt_q < BINS);
  assign y_beat = (state_q == S_COLLECT) && yValid && (y_cnt_q < BINS);

  always_comb begin
    state_d        = state_q;
    x_cnt_d        = x_cnt_q;
    y_cnt_d        = y_cnt_q;
    x_idx_d        = x_idx_q;
    y_idx_d        = y_idx_q;
    x_peak_d       = x_peak_q;
    y_peak_d       = y_peak_q;
    tmo_d          = tmo_q;
    err_d          = err_q;
    readHistogram  = 1'b0;
    clearHistogram = 1'b0;
`ifdef HIST_TOTAL_EN
    x_tot_d        = x_tot_q;
    y_tot_d        = y_tot_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (filterDone) state_d = S_REQUEST;
      end
      S_REQUEST: begin
        readHistogram = 1'b1;
        x_cnt_d       = '0;
        y_cnt_d       = '0;
        x_idx_d       = '0;
        y_idx_d       = '0;
        x_peak_d      = '0;
        y_peak_d      = '0;
`ifdef HIST_TOTAL_EN
        x_tot_d       = '0;
        y_tot_d       = '0;
`endif
        state_d       = S_COLLECT;
      end
      S_COLLECT: begin
        if ((x_cnt_q == BINS) && (y_cnt_q == BINS)) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        clearHistogram = 1'b1;
        tmo_d          = TIMEOUT;
        state_d        = S_WAIT_CLEAR;
      end
      S_WAIT_CLEAR: begin
        // Timing out when the counter is about to hit zero makes the error
        // and the result appear CLEAR_TIMEOUT+1 cycles after CLEAR.
        if (histogramClear) begin
          state_d = S_DONE;
        end else if (tmo_q <= 16'd1) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q - 16'd1;
        end
      end
      S_DONE: begin
        if (resultAck) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Strictly greater keeps the lowest index on ties.
    if (x_beat) begin
      x_cnt_d = x_cnt_q + 9'd1;
      if (xHistogramOut > x_peak_q) begin
        x_peak_d = xHistogramOut;
        x_idx_d  = x_cnt_q[7:0];
      end
`ifdef HIST_TOTAL_EN
      x_tot_d = x_tot_q + 16'(xHistogramOut);
`endif
    end
    if (y_beat) begin
      y_cnt_d = y_cnt_q + 9'd1;
      if (yHistogramOut > y_peak_q) begin
        y_peak_d = yHistogramOut;
        y_idx_d  = y_cnt_q[7:0];
      end
`ifdef HIST_TOTAL_EN
      y_tot_d = y_tot_q + 16'(yHistogramOut);
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      x_cnt_q  <= '0;
      y_cnt_q  <= '0;
      x_idx_q  <= '0;
      y_idx_q  <= '0;
      x_peak_q <= '0;
      y_peak_q <= '0;
      tmo_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_cnt_q  <= x_cnt_d;
      y_cnt_q  <= y_cnt_d;
      x_idx_q  <= x_idx_d;
      y_idx_q  <= y_idx_d;
      x_peak_q <= x_peak_d;
      y_peak_q <= y_peak_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
    end
  end

`ifdef HIST_TOTAL_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_tot_q <= '0;
      y_tot_q <= '0;
    end else begin
      x_tot_q <= x_tot_d;
      y_tot_q <= y_tot_d;
    end
  end
  assign xTotal = x_tot_q;
  assign yTotal = y_tot_q;
`else
  assign xTotal = '0;
  assign yTotal = '0;
`endif

  assign xPeakIndex  = x_idx_q;
  assign yPeakIndex  = y_idx_q;
  assign xPeakCount  = x_peak_q;
  assign yPeakCount  = y_peak_q;
  assign clearError  = err_q;
  assign resultValid = (state_q == S_DONE);
  assign busy        = (state_q != S_IDLE);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_histogram_peak_reader.sv
// Bench for histogram_peak_reader: directed streams, a queue-based model
// of the accepted bins, a negedge monitor comparing the offered result,
// and literal expectations for each scenario.
module tb_histogram_peak_reader;
  localparam int NB  = 256;
  localparam int TMO = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        filterDone, readHistogram, clearHistogram;
  logic [7:0]  xHistogramOut, yHistogramOut;
  logic        xValid, yValid, histogramClear;
  logic [7:0]  xPeakIndex, yPeakIndex, xPeakCount, yPeakCount;
  logic [15:0] xTotal, yTotal;
  logic        resultValid, resultAck, clearError, busy;
  logic [2:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  int rh_count = 0;

  logic [7:0] x_src[$];
  logic [7:0] y_src[$];
  logic [7:0] x_model_q[$];
  logic [7:0] y_model_q[$];

  histogram_peak_reader #(.NUM_BINS(NB), .CLEAR_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(rst_n), .filterDone(filterDone),
    .readHistogram(readHistogram), .clearHistogram(clearHistogram),
    .xHistogramOut(xHistogramOut), .yHistogramOut(yHistogramOut),
    .xValid(xValid), .yValid(yValid), .histogramClear(histogramClear),
    .xPeakIndex(xPeakIndex), .yPeakIndex(yPeakIndex),
    .xPeakCount(xPeakCount), .yPeakCount(yPeakCount),
    .xTotal(xTotal), .yTotal(yTotal), .resultValid(resultValid),
    .resultAck(resultAck), .clearError(clearError), .busy(busy),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Peak = first bin holding the maximum count (0/0 when all zero); total = sum.
  function automatic void model_axis(input bit is_y, output int idx, output int cnt,
                                     output int tot);
    logic [7:0] q[$];
    if (is_y) q = y_model_q;
    else      q = x_model_q;
    idx = 0; cnt = 0; tot = 0;
    for (int i = 0; i < q.size(); i++) begin
      if (int'(q[i]) > cnt) begin
        cnt = int'(q[i]);
        idx = i;
      end
      tot += int'(q[i]);
    end
  endfunction

  // Monitor: whenever a result is offered it must match the model.
  always @(negedge clk) begin
    int xi, xc, xt, yi, yc, yt;
    if (readHistogram) rh_count++;
    if (rst_n && resultValid) begin
      model_axis(1'b0, xi, xc, xt);
      model_axis(1'b1, yi, yc, yt);
`ifndef HIST_TOTAL_EN
      xt = 0;
      yt = 0;
`endif
      check("mon_x_index", 32'(xPeakIndex), 32'(xi));
      check("mon_x_count", 32'(xPeakCount), 32'(xc));
      check("mon_y_index", 32'(yPeakIndex), 32'(yi));
      check("mon_y_count", 32'(yPeakCount), 32'(yc));
      check("mon_x_total", 32'(xTotal), 32'(xt));
      check("mon_y_total", 32'(yTotal), 32'(yt));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_readHistogram"}, 32'(readHistogram), 0);
    check({tag, "_clearHistogram"}, 32'(clearHistogram), 0);
    check({tag, "_xPeakIndex"}, 32'(xPeakIndex), 0);
    check({tag, "_yPeakIndex"}, 32'(yPeakIndex), 0);
    check({tag, "_xPeakCount"}, 32'(xPeakCount), 0);
    check({tag, "_yPeakCount"}, 32'(yPeakCount), 0);
    check({tag, "_xTotal"}, 32'(xTotal), 0);
    check({tag, "_yTotal"}, 32'(yTotal), 0);
    check({tag, "_resultValid"}, 32'(resultValid), 0);
    check({tag, "_clearError"}, 32'(clearError), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_state"}, 32'(dbg_state), 0);
  endtask

  task automatic start_read();
    x_model_q.delete();
    y_model_q.delete();
    filterDone = 1'b1;
    tick();
    filterDone = 1'b0;
    sample();
    check("read_pulse", 32'(readHistogram), 1);
    check("busy_request", 32'(busy), 1);
    tick();
    sample();
    check("read_single_cycle", 32'(readHistogram), 0);
  endtask

  // Beats for x start at cycle xs (xn of them), y at ys; filterDone pulses
  // at cycle fd_at (negative for never). Model keeps only the first NB beats.
  task automatic drive_streams(input int xs, input int xn, input int ys, input int yn,
                               input int fd_at);
    int last;
    last = (xs + xn > ys + yn) ? xs + xn : ys + yn;
    for (int c = 0; c < last; c++) begin
      xValid = (c >= xs) && (c < xs + xn);
      yValid = (c >= ys) && (c < ys + yn);
      xHistogramOut = xValid ? x_src[c - xs] : 8'd0;
      yHistogramOut = yValid ? y_src[c - ys] : 8'd0;
      if (xValid && x_model_q.size() < NB) x_model_q.push_back(x_src[c - xs]);
      if (yValid && y_model_q.size() < NB) y_model_q.push_back(y_src[c - ys]);
      filterDone = (c == fd_at);
      tick();
    end
    xValid = 1'b0;
    yValid = 1'b0;
    xHistogramOut = 8'd0;
    yHistogramOut = 8'd0;
    filterDone = 1'b0;
  endtask

  // Entered in the cycle after the last beat edge M; ends in the first DONE cycle.
  task automatic finish_clear(input bit give_ack);
    sample();
    check("clear_not_early", 32'(clearHistogram), 0);
    tick();
    sample();
    check("clear_pulse_m2", 32'(clearHistogram), 1);
    if (give_ack) begin
      tick();
      histogramClear = 1'b1;
      sample();
      check("valid_not_before_ack", 32'(resultValid), 0);
      check("clear_single_cycle", 32'(clearHistogram), 0);
      tick();
      histogramClear = 1'b0;
      sample();
      check("valid_at_m4", 32'(resultValid), 1);
      check("no_clear_error", 32'(clearError), 0);
    end else begin
      for (int k = 1; k <= TMO; k++) begin
        tick();
        sample();
        check("tmo_valid_low", 32'(resultValid), 0);
        check("tmo_error_low", 32'(clearError), 0);
        if (k == 1) check("tmo_clear_single", 32'(clearHistogram), 0);
      end
      tick();
      sample();
      check("tmo_valid_high", 32'(resultValid), 1);
      check("tmo_error_high", 32'(clearError), 1);
    end
  endtask

  task automatic ack_result(input int hold);
    for (int k = 0; k < hold; k++) begin
      tick();
      sample();
      check("valid_held", 32'(resultValid), 1);
    end
    resultAck = 1'b1;
    tick();
    resultAck = 1'b0;
    sample();
    check("valid_drop_after_ack", 32'(resultValid), 0);
    check("idle_after_ack", 32'(busy), 0);
  endtask

  task automatic check_peaks(input string tag, input int xi, input int xc, input int yi,
                             input int yc);
    check({tag, "_x_index"}, 32'(xPeakIndex), 32'(xi));
    check({tag, "_x_count"}, 32'(xPeakCount), 32'(xc));
    check({tag, "_y_index"}, 32'(yPeakIndex), 32'(yi));
    check({tag, "_y_count"}, 32'(yPeakCount), 32'(yc));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0;
    filterDone = 1'b0;
    xHistogramOut = '0;
    yHistogramOut = '0;
    xValid = 1'b0;
    yValid = 1'b0;
    histogramClear = 1'b0;
    resultAck = 1'b0;

    repeat (3) tick();
    sample();
    check_all_zero("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // 1: x bins = index, y bins all 7
    x_src.delete(); y_src.delete();
    for (int i = 0; i < NB; i++) begin
      x_src.push_back(8'(i));
      y_src.push_back(8'd7);
    end
    start_read();
    drive_streams(0, NB, 0, NB, -1);
    finish_clear(1'b1);
    check_peaks("ramp", 255, 255, 0, 7);
`ifdef HIST_TOTAL_EN
    check("ramp_x_total", 32'(xTotal), 32640);
    check("ramp_y_total", 32'(yTotal), 1792);
`else
    check("ramp_x_total", 32'(xTotal), 0);
    check("ramp_y_total", 32'(yTotal), 0);
`endif
    ack_result(0);

    // 2: tie between bins 10 and 200
    x_src.delete(); y_src.delete();
    for (int i = 0; i < NB; i++) begin
      x_src.push_back((i == 10 || i == 200) ? 8'd99 : 8'd0);
      y_src.push_back((i == 10 || i == 200) ? 8'd99 : 8'd0);
    end
    start_read();
    drive_streams(0, NB, 0, NB, -1);
    finish_clear(1'b1);
    check_peaks("tie", 10, 99, 10, 99);
    ack_result(2);

    // 3: x finishes 50 cycles early, then 3 extra x beats of 250
    x_src.delete(); y_src.delete();
    for (int i = 0; i < NB; i++) begin
      x_src.push_back(8'(i % 100));
      y_src.push_back(8'(i / 2));
    end
    for (int i = 0; i < 3; i++) x_src.push_back(8'd250);
    start_read();
    drive_streams(0, NB + 3, 50, NB, -1);
    finish_clear(1'b1);
    check_peaks("skew", 99, 99, 254, 127);
    ack_result(1);

    // 6: second filterDone mid-collect, ack withheld 20 cycles
    x_src.delete(); y_src.delete();
    for (int i = 0; i < NB; i++) begin
      x_src.push_back(8'(i * 3));
      y_src.push_back(8'(255 - i));
    end
    rh_count = 0;
    start_read();
    drive_streams(0, NB, 0, NB, 100);
    finish_clear(1'b1);
    check_peaks("hold", 85, 255, 0, 255);
    ack_result(20);
    check("single_read_request", 32'(rh_count), 1);

    // 4: no clear acknowledge -> timeout
    x_src.delete(); y_src.delete();
    for (int i = 0; i < NB; i++) begin
      x_src.push_back(8'(i ^ 8'h33));
      y_src.push_back(8'(i + 17));
    end
    start_read();
    drive_streams(0, NB, 3, NB, -1);
    finish_clear(1'b0);
    ack_result(0);
    check("error_sticky", 32'(clearError), 1);

    // 5: reset during COLLECT, then a fresh readout
    x_src.delete(); y_src.delete();
    for (int i = 0; i < 100; i++) begin
      x_src.push_back(8'(i * 5));
      y_src.push_back(8'd240);
    end
    start_read();
    drive_streams(0, 100, 0, 100, -1);
    rst_n = 1'b0;
    sample();
    check_all_zero("midreset");
    tick();
    sample();
    check("midreset_busy", 32'(busy), 0);
    check("midreset_no_clear", 32'(clearHistogram), 0);
    tick();
    rst_n = 1'b1;
    tick();
    x_src.delete(); y_src.delete();
    for (int i = 0; i < NB; i++) begin
      x_src.push_back(8'(i * 37));
      y_src.push_back((i == 77) ? 8'd200 : 8'(i % 50));
    end
    start_read();
    drive_streams(0, NB, 0, NB, -1);
    finish_clear(1'b1);
    check_peaks("after_reset", 83, 255, 77, 200);
    ack_result(0);

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/histogram_peak_reader.md
# histogram_peak_reader

Consumer of the histogram readout interface. On `filterDone` it requests a histogram readout, receives the streamed x and y projection bins, and tracks the peak bin (index and count) per axis. It then clears the histogram and presents the result to the downstream tracking logic through a valid/ack handshake. It sits beside the filter and histogram blocks and drives their `readHistogram`/`clearHistogram` inputs.

## Interface
- `NUM_BINS`, 256: bins per axis; legal range 2..256.
- `CLEAR_TIMEOUT`, 1023: cycles to wait for `histogramClear` before flagging an error; legal range 1..65535.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `filterDone`  in  1  one-cycle pulse; starts a readout.
- `readHistogram`  out  1  one-cycle request to start bin streaming.
- `clearHistogram`  out  1  one-cycle request to clear the histogram.
- `xHistogramOut`  in  8  x bin count, qualified by `xValid`.
- `yHistogramOut`  in  8  y bin count, qualified by `yValid`.
- `xValid`, `yValid`  in  1  one bin per axis per high cycle, in order from bin 0.
- `histogramClear`  in  1  clear-complete acknowledge, level or pulse.
- `xPeakIndex`, `yPeakIndex`  out  8  bin index of the maximum count.
- `xPeakCount`, `yPeakCount`  out  8  maximum count.
- `xTotal`, `yTotal`  out  16  sum of all bin counts (see Configuration).
- `resultValid`  out  1  result held stable while high.
- `resultAck`  in  1  consumer accepts the result.
- `clearError`  out  1  sticky flag: the clear acknowledge timed out.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, REQUEST, COLLECT, CLEAR, WAIT_CLEAR, DONE.
- IDLE:
  - `filterDone` moves to REQUEST.
  - `xValid`/`yValid`/`histogramClear` are ignored.
- REQUEST:
  - `readHistogram`=1 for exactly this cycle.
  - Clears all accumulators and bin counters, then moves to COLLECT.
- COLLECT:
  - The x and y streams are independent and may interleave or overlap.
  - Each axis has a 9-bit beat counter; the beat number is the bin index.
  - On a valid beat, the peak updates only when the count is strictly greater than the stored peak, so ties keep the lowest index.
  - The stored peak starts at index 0, count 0, so an all-zero axis reports index 0, count 0.
  - Beats arriving after an axis reaches `NUM_BINS` are ignored.
  - The state exits to CLEAR in the cycle after both counters reach `NUM_BINS`.
- CLEAR:
  - `clearHistogram`=1 for exactly this cycle, then moves to WAIT_CLEAR.
  - Reloads the timeout counter with `CLEAR_TIMEOUT`.
- WAIT_CLEAR:
  - `histogramClear`=1 moves to DONE.
  - Counter reaching 0 sets `clearError` and moves to DONE.
  - `clearError` is sticky until reset.
- DONE:
  - `resultValid`=1; result outputs stay frozen.
  - `resultAck` returns to IDLE the next cycle, with `resultValid` dropping.
- `filterDone` outside IDLE is ignored; there is no queueing.
- Result registers keep the last result until the next REQUEST.

## Timing
- Reset values: every output is 0, and the state is IDLE.
- Reset mid-operation aborts immediately; no clear is issued.
- Start latency:
  - `filterDone` at edge N gives `readHistogram` high in cycle N+1.
  - COLLECT starts at N+2.
- Peak registers update on the edge that samples the valid beat.
- Final-beat to done latency:
  - Last beat of the slower axis at edge M gives `clearHistogram` high in cycle M+2.
  - `resultValid` rises no earlier than M+4, when `histogramClear` returns in the first WAIT_CLEAR cycle.
- Timeout: with no acknowledge, `clearError` and `resultValid` rise `CLEAR_TIMEOUT`+1 cycles after CLEAR.
- `resultAck` is sampled only in DONE. Asserting it in the same cycle `resultValid` rises is legal.
- Arithmetic:
  - Totals are 16-bit unsigned; 256×255 cannot overflow.
  - Count comparisons are 8-bit unsigned.

## Configuration
- `HIST_TOTAL_EN`:
  - Defined: `xTotal`/`yTotal` accumulate every accepted beat and are frozen with the result.
  - Undefined: the accumulators are not built, and `xTotal`/`yTotal` are tied to 0. All ports remain present.

## Test plan
- `NUM_BINS`=256, x bins = index[7:0], y bins all 7, `histogramClear` one cycle after clear:
  - xPeak (255, 255), yPeak (0, 7).
  - With the macro: xTotal=32640, yTotal=1792.
- Bins 10 and 200 both 99 (others 0) on both axes: peak index 10, count 99.
- x stream completes 50 cycles before y; 3 extra x beats injected: result ignores extras, and `clearHistogram` fires two cycles after the last y beat.
- `histogramClear` never asserted, `CLEAR_TIMEOUT`=5: `clearError`=1 and `resultValid`=1 six cycles after the clear pulse.
- `reset` low mid-COLLECT, then a new `filterDone`: outputs all 0 during reset; a fresh `readHistogram`; result reflects only the new stream.
- Second `filterDone` in COLLECT and `resultAck` withheld 20 cycles: one `readHistogram` only; result stable all 20 cycles; IDLE one cycle after ack.
